// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types for the memory sequencing bridge.
// State encoding, fault cause codes, NOP word, alignment helper.
package mem_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_F_REQ  = 3'd1,
      S_F_WAIT = 3'd2,
      S_EXEC   = 3'd3,
      S_D_WAIT = 3'd4,
      S_RETIRE = 3'd5,
      S_FAULT  = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      C_NONE     = 2'd0,
      C_MISALIGN = 2'd1,
      C_TIMEOUT  = 2'd2,
      C_RDWR     = 2'd3
   } cause_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic misaligned(input logic [1:0] lo);
      return |lo;
   endfunction

endpackage

// File: rtl/mem_seq_wbuf.sv
// mem_seq_wbuf: one-entry posted write buffer with load-match lookup.
// Ports: i_load/i_addr/i_data fill, i_clear drains, i_lookup -> o_hit; o_valid/o_addr/o_data.
module mem_seq_wbuf (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data,
   input  logic        i_clear,
   input  logic [31:0] i_lookup,
   output logic        o_valid,
   output logic [31:0] o_addr,
   output logic [31:0] o_data,
   output logic        o_hit
);

   logic        r_valid;
   logic [31:0] r_addr;
   logic [31:0] r_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         if (i_clear) r_valid <= 1'b0;
         if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_addr  = r_addr;
   assign o_data  = r_data;
   assign o_hit   = r_valid && (r_addr == i_lookup);

endmodule

// File: rtl/mem_seq_bridge.sv
// mem_seq_bridge: sequences core fetch / load / store onto a single-port word bus.
// Ports: core side (instr_addr, data_addr, should_*_mem, mem_write_data, exec_hold,
// instr, mem_read_data, core_stall), bus side (bus_req/we/addr/wdata, bus_gnt,
// bus_rvalid, bus_rdata), fault/fault_cause. Option: MEM_SEQ_BRIDGE_WBUF_EN.
module mem_seq_bridge
   import mem_seq_pkg::*;
#(
   parameter int TIMEOUT        = 255,
   parameter bit RESET_PC_FETCH = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] instr_addr,
   input  logic [31:0] data_addr,
   input  logic        should_read_mem,
   input  logic        should_write_mem,
   input  logic [31:0] mem_write_data,
   input  logic        exec_hold,
   output logic [31:0] instr,
   output logic [31:0] mem_read_data,
   output logic        core_stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic        fault,
   output logic [1:0]  fault_cause
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e          r_state;
   state_e          w_next;
   cause_e          w_cause;
   logic [1:0]      r_cause;
   logic [TW-1:0]   r_tcnt;
   logic            w_i_mis;
   logic            w_d_mis;
   logic            w_exec_ok;
   logic            w_wait;
   logic            w_tout;
   logic            w_req;
   logic            w_we;
   logic [31:0]     w_addr;
   logic [31:0]     w_wdata;

   assign w_i_mis = misaligned(instr_addr[1:0]);
   assign w_d_mis = misaligned(data_addr[1:0]);

   // EXEC is free of hold and of both fault conditions
   assign w_exec_ok = (r_state == S_EXEC) && !exec_hold
                    && !(should_read_mem && should_write_mem)
                    && !((should_read_mem || should_write_mem) && w_d_mis);

`ifdef MEM_SEQ_BRIDGE_WBUF_EN
   logic        w_wb_valid;
   logic        w_wb_hit;
   logic        w_fwd;
   logic        w_drain;
   logic        w_wb_load;
   logic [31:0] w_wb_addr;
   logic [31:0] w_wb_data;

   assign w_fwd = w_exec_ok && should_read_mem && w_wb_hit;
   // buffered write owns the bus in F_REQ, and in EXEC whenever a memory op needs it
   assign w_drain = w_wb_valid
                  && (((r_state == S_F_REQ) && !w_i_mis)
                      || (w_exec_ok && !w_fwd
                          && (should_read_mem || should_write_mem)));
   assign w_wb_load = w_exec_ok && should_write_mem && !w_wb_valid;

   mem_seq_wbuf u_wbuf (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_wb_load),
      .i_addr   (data_addr),
      .i_data   (mem_write_data),
      .i_clear  (w_drain && bus_gnt),
      .i_lookup (data_addr),
      .o_valid  (w_wb_valid),
      .o_addr   (w_wb_addr),
      .o_data   (w_wb_data),
      .o_hit    (w_wb_hit)
   );
`endif

   assign w_wait = w_req || (r_state == S_F_WAIT) || (r_state == S_D_WAIT);
   assign w_tout = (TIMEOUT != 0) && w_wait && (r_tcnt == TLAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if (RESET_PC_FETCH) r_state <= S_F_REQ;
         else                r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_cause = C_NONE;
      case (r_state)
         S_IDLE: if (start) w_next = S_F_REQ;
         S_F_REQ: begin
            if (w_i_mis) begin
               w_next  = S_FAULT;
               w_cause = C_MISALIGN;
            end else if (bus_gnt) begin
`ifdef MEM_SEQ_BRIDGE_WBUF_EN
               if (!w_wb_valid) w_next = S_F_WAIT;
`else
               w_next = S_F_WAIT;
`endif
            end else if (w_tout) begin
               w_next  = S_FAULT;
               w_cause = C_TIMEOUT;
            end
         end
         S_F_WAIT: begin
            if (bus_rvalid) begin
               w_next = S_EXEC;
            end else if (w_tout) begin
               w_next  = S_FAULT;
               w_cause = C_TIMEOUT;
            end
         end
         S_EXEC: begin
            if (!exec_hold) begin
               if (should_read_mem && should_write_mem) begin
                  w_next  = S_FAULT;
                  w_cause = C_RDWR;
               end else if ((should_read_mem || should_write_mem) && w_d_mis) begin
                  w_next  = S_FAULT;
                  w_cause = C_MISALIGN;
`ifdef MEM_SEQ_BRIDGE_WBUF_EN
               end else if (w_fwd) begin
                  w_next = S_RETIRE;
               end else if (w_drain) begin
                  if (!bus_gnt && w_tout) begin
                     w_next  = S_FAULT;
                     w_cause = C_TIMEOUT;
                  end
               end else if (should_read_mem) begin
                  if (bus_gnt) begin
                     w_next = S_D_WAIT;
                  end else if (w_tout) begin
                     w_next  = S_FAULT;
                     w_cause = C_TIMEOUT;
                  end
`else
               end else if (should_read_mem) begin
                  if (bus_gnt) begin
                     w_next = S_D_WAIT;
                  end else if (w_tout) begin
                     w_next  = S_FAULT;
                     w_cause = C_TIMEOUT;
                  end
               end else if (should_write_mem) begin
                  if (bus_gnt) begin
                     w_next = S_RETIRE;
                  end else if (w_tout) begin
                     w_next  = S_FAULT;
                     w_cause = C_TIMEOUT;
                  end
`endif
               end else begin
                  w_next = S_RETIRE;
               end
            end
         end
         S_D_WAIT: begin
            if (bus_rvalid) begin
               w_next = S_RETIRE;
            end else if (w_tout) begin
               w_next  = S_FAULT;
               w_cause = C_TIMEOUT;
            end
         end
         S_RETIRE: if (!exec_hold) w_next = S_F_REQ;
         default: w_next = r_state;
      endcase
   end

   always_comb begin
      w_req      = 1'b0;
      w_we       = 1'b0;
      w_addr     = '0;
      w_wdata    = '0;
      core_stall = !((r_state == S_RETIRE) && !exec_hold);
      case (r_state)
         S_F_REQ: begin
            if (!w_i_mis) begin
               w_req  = 1'b1;
               w_addr = instr_addr;
`ifdef MEM_SEQ_BRIDGE_WBUF_EN
               if (w_wb_valid) begin
                  w_we    = 1'b1;
                  w_addr  = w_wb_addr;
                  w_wdata = w_wb_data;
               end
`endif
            end
         end
         S_EXEC: begin
            if (w_exec_ok) begin
`ifdef MEM_SEQ_BRIDGE_WBUF_EN
               if (w_drain) begin
                  w_req   = 1'b1;
                  w_we    = 1'b1;
                  w_addr  = w_wb_addr;
                  w_wdata = w_wb_data;
               end else if (should_read_mem && !w_fwd) begin
                  w_req  = 1'b1;
                  w_addr = data_addr;
               end
`else
               if (should_read_mem || should_write_mem) begin
                  w_req  = 1'b1;
                  w_we   = should_write_mem;
                  w_addr = data_addr;
                  if (should_write_mem) w_wdata = mem_write_data;
               end
`endif
            end
         end
         default: w_req = 1'b0;
      endcase
   end

   // reset drops the request combinationally, even though reset state may be F_REQ
   assign bus_req   = w_req & ~reset;
   assign bus_we    = w_we & ~reset;
   assign bus_addr  = reset ? '0 : (w_addr & 32'hFFFF_FFFC);
   assign bus_wdata = reset ? '0 : w_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr         <= NOP_INSTR;
         mem_read_data <= '0;
         r_cause       <= C_NONE;
         r_tcnt        <= '0;
      end else begin
         if ((r_state == S_F_WAIT) && bus_rvalid) instr <= bus_rdata;
         if ((r_state == S_D_WAIT) && bus_rvalid) mem_read_data <= bus_rdata;
`ifdef MEM_SEQ_BRIDGE_WBUF_EN
         if (w_fwd) mem_read_data <= w_wb_data;
`endif
         if ((w_next == S_FAULT) && (r_state != S_FAULT)) r_cause <= w_cause;
         // a grant also restarts the count so a drain does not eat the fetch budget
         if ((w_next != r_state) || (w_req && bus_gnt)) r_tcnt <= '0;
         else if (w_wait)                                r_tcnt <= r_tcnt + TW'(1);
      end
   end

   assign fault       = (r_state == S_FAULT);
   assign fault_cause = r_cause;

endmodule

// File: tb/tb_mem_seq_bridge.sv
// tb_mem_seq_bridge: directed self-checking bench for mem_seq_bridge.
// Main DUT: TIMEOUT=4, auto fetch; second DUT: start-pulse fetch.
module tb_mem_seq_bridge;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] instr_addr;
   logic [31:0] data_addr;
   logic        should_read_mem;
   logic        should_write_mem;
   logic [31:0] mem_write_data;
   logic        exec_hold;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   logic [31:0] instr;
   logic [31:0] mem_read_data;
   logic        core_stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        fault;
   logic [1:0]  fault_cause;

   logic [31:0] d2_instr;
   logic [31:0] d2_mem_read_data;
   logic        d2_core_stall;
   logic        d2_bus_req;
   logic        d2_bus_we;
   logic [31:0] d2_bus_addr;
   logic [31:0] d2_bus_wdata;
   logic        d2_fault;
   logic [1:0]  d2_fault_cause;

   int n_chk = 0;
   int n_err = 0;

   mem_seq_bridge #(.TIMEOUT(4), .RESET_PC_FETCH(1'b1)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .instr_addr       (instr_addr),
      .data_addr        (data_addr),
      .should_read_mem  (should_read_mem),
      .should_write_mem (should_write_mem),
      .mem_write_data   (mem_write_data),
      .exec_hold        (exec_hold),
      .instr            (instr),
      .mem_read_data    (mem_read_data),
      .core_stall       (core_stall),
      .bus_req          (bus_req),
      .bus_we           (bus_we),
      .bus_addr         (bus_addr),
      .bus_wdata        (bus_wdata),
      .bus_gnt          (bus_gnt),
      .bus_rvalid       (bus_rvalid),
      .bus_rdata        (bus_rdata),
      .fault            (fault),
      .fault_cause      (fault_cause)
   );

   mem_seq_bridge #(.TIMEOUT(255), .RESET_PC_FETCH(1'b0)) u_dut2 (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .instr_addr       (instr_addr),
      .data_addr        (data_addr),
      .should_read_mem  (should_read_mem),
      .should_write_mem (should_write_mem),
      .mem_write_data   (mem_write_data),
      .exec_hold        (exec_hold),
      .instr            (d2_instr),
      .mem_read_data    (d2_mem_read_data),
      .core_stall       (d2_core_stall),
      .bus_req          (d2_bus_req),
      .bus_we           (d2_bus_we),
      .bus_addr         (d2_bus_addr),
      .bus_wdata        (d2_bus_wdata),
      .bus_gnt          (bus_gnt),
      .bus_rvalid       (bus_rvalid),
      .bus_rdata        (bus_rdata),
      .fault            (d2_fault),
      .fault_cause      (d2_fault_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // from F_REQ: grant, then read data one cycle later; ends in EXEC
   task automatic fetch(input logic [31:0] pc, input logic [31:0] word);
      instr_addr = pc;
      bus_gnt    = 1'b1;
      tick;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = word;
      tick;
      bus_rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b1;
      start            = 1'b0;
      instr_addr       = '0;
      data_addr        = '0;
      should_read_mem  = 1'b0;
      should_write_mem = 1'b0;
      mem_write_data   = '0;
      exec_hold        = 1'b0;
      bus_gnt          = 1'b0;
      bus_rvalid       = 1'b0;
      bus_rdata        = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_mrd", mem_read_data, 32'h0);
      check("rst_stall", 32'(core_stall), 32'd1);
      check("rst_req", 32'(bus_req), 32'd0);
      check("rst_we", 32'(bus_we), 32'd0);
      check("rst_addr", bus_addr, 32'h0);
      check("rst_wdata", bus_wdata, 32'h0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_cause", 32'(fault_cause), 32'd0);

      reset = 1'b0;
      #1;
      check("f1_req", 32'(bus_req), 32'd1);
      check("f1_addr", bus_addr, 32'h0);
      check("f1_stall", 32'(core_stall), 32'd1);
      check("d2_idle_req", 32'(d2_bus_req), 32'd0);

      start   = 1'b1;
      bus_gnt = 1'b1;
      tick;
      start = 1'b0;
      #1;
      check("d2_start_req", 32'(d2_bus_req), 32'd1);
      check("f2_req", 32'(bus_req), 32'd0);
      check("f2_stall", 32'(core_stall), 32'd1);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h0050_0093;
      tick;
      bus_rvalid = 1'b0;
      #1;
      check("f3_instr", instr, 32'h0050_0093);
      check("f3_stall", 32'(core_stall), 32'd1);
      check("f3_req", 32'(bus_req), 32'd0);
      tick;
      check("f4_stall", 32'(core_stall), 32'd0);
      tick;
      check("f5_stall", 32'(core_stall), 32'd1);
      check("f5_req", 32'(bus_req), 32'd1);
      check("f5_addr", bus_addr, 32'h0);

      fetch(32'h4, 32'h1000_2083);
      should_read_mem = 1'b1;
      data_addr       = 32'h100;
      #1;
      check("ld_req", 32'(bus_req), 32'd1);
      check("ld_we", 32'(bus_we), 32'd0);
      check("ld_addr0", bus_addr, 32'h100);
      tick;
      check("ld_addr1", bus_addr, 32'h100);
      tick;
      check("ld_addr2", bus_addr, 32'h100);
      check("ld_req2", 32'(bus_req), 32'd1);
      bus_gnt = 1'b1;
      tick;
      bus_gnt = 1'b0;
      #1;
      check("ld_dwait_req", 32'(bus_req), 32'd0);
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hDEAD_BEEF;
      tick;
      bus_rvalid      = 1'b0;
      should_read_mem = 1'b0;
      #1;
      check("ld_mrd", mem_read_data, 32'hDEAD_BEEF);
      check("ld_ret_stall", 32'(core_stall), 32'd0);
      tick;

      fetch(32'h8, 32'h0020_a223);
      should_write_mem = 1'b1;
      data_addr        = 32'h104;
      mem_write_data   = 32'h1234_5678;
      exec_hold        = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("st_hold_req", 32'(bus_req), 32'd0);
         check("st_hold_stall", 32'(core_stall), 32'd1);
         tick;
      end
      exec_hold = 1'b0;
      #1;
`ifdef MEM_SEQ_BRIDGE_WBUF_EN
      check("st_buf_req", 32'(bus_req), 32'd0);
      tick;
      should_write_mem = 1'b0;
      #1;
      check("st_ret_stall", 32'(core_stall), 32'd0);
      check("st_ret_req", 32'(bus_req), 32'd0);
      tick;
      check("st_drain_req", 32'(bus_req), 32'd1);
      check("st_drain_we", 32'(bus_we), 32'd1);
      check("st_drain_addr", bus_addr, 32'h104);
      check("st_drain_wdata", bus_wdata, 32'h1234_5678);
      bus_gnt = 1'b1;
      tick;
      bus_gnt = 1'b0;
      #1;
      check("st_fetch_we", 32'(bus_we), 32'd0);
`else
      check("st_req", 32'(bus_req), 32'd1);
      check("st_we", 32'(bus_we), 32'd1);
      check("st_addr", bus_addr, 32'h104);
      check("st_wdata", bus_wdata, 32'h1234_5678);
      bus_gnt = 1'b1;
      tick;
      bus_gnt          = 1'b0;
      should_write_mem = 1'b0;
      #1;
      check("st_ret_stall", 32'(core_stall), 32'd0);
      check("st_ret_req", 32'(bus_req), 32'd0);
      tick;
`endif
      check("st_next_req", 32'(bus_req), 32'd1);

      fetch(32'hC, 32'h0020_a083);
      should_read_mem = 1'b1;
      data_addr       = 32'h102;
      #1;
      check("mis_req", 32'(bus_req), 32'd0);
      tick;
      should_read_mem = 1'b0;
      #1;
      check("mis_fault", 32'(fault), 32'd1);
      check("mis_cause", 32'(fault_cause), 32'd1);
      check("mis_stall", 32'(core_stall), 32'd1);
      repeat (3) tick;
      check("mis_stall_hold", 32'(core_stall), 32'd1);
      check("mis_fault_hold", 32'(fault), 32'd1);
      check("mis_req_hold", 32'(bus_req), 32'd0);

      reset = 1'b1;
      tick;
      reset = 1'b0;
      #1;
      check("rr_fault", 32'(fault), 32'd0);
      check("rr_cause", 32'(fault_cause), 32'd0);
      check("rr_req", 32'(bus_req), 32'd1);
      check("d2_rr_req", 32'(d2_bus_req), 32'd0);
      reset = 1'b1;
      #1;
      check("mid_rst_req", 32'(bus_req), 32'd0);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("to_req", 32'(bus_req), 32'd1);
         tick;
      end
      check("to_fault", 32'(fault), 32'd1);
      check("to_cause", 32'(fault_cause), 32'd2);
      check("to_req_off", 32'(bus_req), 32'd0);
      tick;
      check("to_req_off2", 32'(bus_req), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_seq_bridge.md
Name: mem_seq_bridge

Overview:
- Sequences every core instruction into bus transactions on a single-port word memory bus: instruction fetch, then an optional data load/store, then a one-cycle retire window.
- Sits directly downstream of the Riscv core's memory-side outputs (instr_addr, data_addr, should_read_mem, should_write_mem, mem_write_data).
- Feeds the core's instr and mem_read_data inputs from registers.
- Provides core_stall; integration gates the core's PC/register/XMM writes with ~core_stall.

Parameters:
- TIMEOUT, 255: max cycles waiting for bus_gnt or bus_rvalid before a timeout fault; 0 disables the timeout.
- RESET_PC_FETCH, 1: 1 means fetch starts automatically after reset; 0 means wait for a start pulse.

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begins fetching when RESET_PC_FETCH=0; ignored otherwise
- instr_addr  in  32  core PC
- data_addr  in  32  core ALU result, used as the data address
- should_read_mem  in  1  core decode of the latched instr: load
- should_write_mem  in  1  core decode of the latched instr: store
- mem_write_data  in  32  core store data
- exec_hold  in  1  core busy (FPU); holds EXEC and RETIRE
- instr  out  32  latched instruction word
- mem_read_data  out  32  latched load data
- core_stall  out  1  low only in RETIRE
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word address (bits [1:0] are always 0)
- bus_wdata  out  32  write data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid; at least one cycle after gnt
- bus_rdata  in  32  read data
- fault  out  1  sticky fault flag
- fault_cause  out  2  0 none, 1 misaligned, 2 timeout, 3 read+write asserted together

Behaviour:
- Reset is asynchronous, active-high; clk and reset are the only clock/reset.
- Reset values:
  - instr = 0x00000013 (NOP)
  - mem_read_data = 0
  - core_stall = 1
  - bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0
  - fault = 0, fault_cause = 0
  - state = F_REQ if RESET_PC_FETCH, else IDLE
- States: IDLE, F_REQ, F_WAIT, EXEC, D_WAIT, RETIRE, FAULT.
- IDLE: start goes to F_REQ.
- F_REQ:
  - bus_req=1, we=0, addr=instr_addr.
  - instr_addr[1:0]!=0 goes to FAULT (cause 1) without issuing a request.
  - bus_gnt goes to F_WAIT.
- F_WAIT: on bus_rvalid, instr <= bus_rdata and go to EXEC.
- EXEC:
  - While exec_hold=1, stay with no request.
  - Both read and write asserted goes to FAULT (cause 3).
  - Read or write with data_addr[1:0]!=0 goes to FAULT (cause 1).
  - Read: bus_req=1, we=0, addr=data_addr; gnt goes to D_WAIT.
  - Write: bus_req=1, we=1, wdata=mem_write_data; gnt goes to RETIRE (posted write).
  - Neither: go to RETIRE.
- D_WAIT: on bus_rvalid, mem_read_data <= bus_rdata and go to RETIRE.
- RETIRE:
  - core_stall=0 for exactly one cycle, then go to F_REQ.
  - If exec_hold=1, stay in RETIRE with core_stall=1 until it drops.
- FAULT: terminal; bus_req=0, core_stall=1; only reset leaves it.
- Bus request outputs are driven combinationally from state and inputs. bus_req stays asserted, with stable addr/we/wdata, until gnt.
- Zero-wait latency:
  - Non-memory instruction: 4 cycles (F_REQ, F_WAIT, EXEC, RETIRE).
  - Store: 4 cycles.
  - Load: 5 cycles.
- Timeout counter:
  - 8-bit wide, or $clog2(TIMEOUT+1) bits.
  - Clears on every state change.
  - Counts in F_REQ, F_WAIT, D_WAIT, and EXEC only while a request is pending.
  - Reaching TIMEOUT goes to FAULT (cause 2).
- Stray bus_rvalid outside F_WAIT/D_WAIT is ignored.
- Reset mid-transaction drops bus_req immediately. The bus must share the same reset, so no responses arrive after it.

Optional Feature:
- Macro: MEM_SEQ_BRIDGE_WBUF_EN.
- When defined, a one-entry posted write buffer (addr, data, valid) is added.
  - An EXEC store loads the buffer and goes to RETIRE without a bus request, unless the buffer is full; if full, EXEC waits.
  - Drain: in F_REQ and EXEC the buffer has bus priority; the write is issued first and valid clears on gnt.
  - A load whose address matches the buffer is forwarded from it: mem_read_data = buffered data, no bus read, go to RETIRE.
- When undefined, stores complete on bus gnt as described above.

Decomposition:
- Shared package mem_seq_pkg contains:
  - state enum
  - NOP_INSTR = 32'h00000013
  - fault_cause codes
- One natural sub-module: mem_seq_wbuf, the write buffer with its match/forward logic, instantiated only under MEM_SEQ_BRIDGE_WBUF_EN.

Test Plan:
- Reset release, RESET_PC_FETCH=1, instr_addr=0 -> next cycle bus_req=1, addr=0; instr=0x00000013; core_stall=1.
- Fetch 0x00500093 with gnt=1 and rvalid one cycle later, no memory op -> instr=0x00500093; core_stall low exactly in cycle 4; F_REQ re-entered in cycle 5.
- Load: data_addr=0x100, gnt delayed 2 cycles, rdata=0xDEADBEEF -> mem_read_data=0xDEADBEEF at RETIRE; bus_addr held at 0x100 through the delay.
- Store: data_addr=0x104, mem_write_data=0x12345678, exec_hold=1 for 3 cycles -> no request during hold; then we=1 with that addr/data; RETIRE the cycle after gnt. With WBUF_EN: no bus write until the next F_REQ, and a following load from 0x104 returns 0x12345678 with no bus read.
- Misaligned data_addr=0x102 on load -> no data request; fault=1, cause=1; core_stall stays 1 until reset.
- TIMEOUT=4, gnt held 0 in F_REQ -> fault cause=2 after 4 cycles; bus_req=0 afterwards.
